// File: rtl/seven_seg_dual_reader.sv
// seven_seg_dual_reader: filters, decodes and sequence-checks an active-low dual 7-segment readback bus
module seven_seg_dual_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic [6:0]               i_Seg1,
    input  logic [6:0]               i_Seg2,
    output logic [3:0]               o_Tens,
    output logic [3:0]               o_Units,
    output logic [6:0]               o_Value,
    output logic                     o_Valid,
    output logic                     o_Update,
    output logic                     o_Invalid,
    output logic                     o_Seq_Err,
    output logic [ERR_CNT_WIDTH-1:0] o_Err_Count
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {S_WAIT_FIRST, S_TRACK} state_t;

    state_t      state;
    logic [13:0] seg_in, smp, pend_pat, acc_pat;
    logic [CW-1:0] cnt, cnt_n;
    logic        pend, acc_vld, hit, fire, legal, seq_ok, err;
    logic [4:0]  d1, d2;
    logic [6:0]  new_val, next_val;

    // {legal, digit} for one active-low {G..A} code
    function automatic logic [4:0] dec(input logic [6:0] s);
        case (~s)
            7'b0111111: dec = 5'h10;
            7'b0000110: dec = 5'h11;
            7'b1011011: dec = 5'h12;
            7'b1001111: dec = 5'h13;
            7'b1100110: dec = 5'h14;
            7'b1101101: dec = 5'h15;
            7'b1111101: dec = 5'h16;
            7'b0000111: dec = 5'h17;
            7'b1111111: dec = 5'h18;
            7'b1101111: dec = 5'h19;
            default:    dec = 5'h00;
        endcase
    endfunction

    // run-length count of the current sample, acceptance qualification and decode of the pending pattern
    always_comb begin
        seg_in   = {i_Seg1, i_Seg2};
        cnt_n    = (seg_in != smp) ? CW'(1) : (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);
        hit      = (cnt_n == CW'(STABLE_CYCLES)) && (cnt != CW'(STABLE_CYCLES));
        fire     = pend && (!acc_vld || pend_pat != acc_pat);
        d1       = dec(pend_pat[13:7]);
        d2       = dec(pend_pat[6:0]);
        legal    = d1[4] & d2[4];
        new_val  = 7'(d1[3:0]) * 7'd10 + 7'(d2[3:0]);
        next_val = (o_Value == 7'd99) ? 7'd0 : o_Value + 7'd1;
        seq_ok   = (new_val == 7'd0) || (new_val == next_val);
        err      = fire && (!legal || (state == S_TRACK && !seq_ok));
    end

    // stability filter: a run reaching STABLE_CYCLES edges raises a one-cycle pending acceptance
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            smp      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_pat <= '0;
        end else begin
            smp      <= seg_in;
            cnt      <= cnt_n;
            pend     <= hit;
            pend_pat <= seg_in;
        end
    end

    // acceptance state machine with registered outputs and saturating error counter
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= S_WAIT_FIRST;
            acc_vld     <= 1'b0;
            acc_pat     <= '0;
            o_Tens      <= '0;
            o_Units     <= '0;
            o_Value     <= '0;
            o_Valid     <= 1'b0;
            o_Update    <= 1'b0;
            o_Invalid   <= 1'b0;
            o_Seq_Err   <= 1'b0;
            o_Err_Count <= '0;
        end else begin
            o_Update  <= 1'b0;
            o_Invalid <= 1'b0;
            o_Seq_Err <= 1'b0;
            if (fire) begin
                acc_pat <= pend_pat;
                // leaving S_TRACK on an illegal pattern forgets it, so a repeat is seen afresh
                acc_vld <= legal || state == S_WAIT_FIRST;
                if (legal) begin
                    o_Tens    <= d1[3:0];
                    o_Units   <= d2[3:0];
                    o_Value   <= new_val;
                    o_Valid   <= 1'b1;
                    o_Update  <= 1'b1;
                    o_Seq_Err <= state == S_TRACK && !seq_ok;
                    state     <= S_TRACK;
                end else begin
                    o_Valid   <= 1'b0;
                    o_Invalid <= 1'b1;
                    state     <= S_WAIT_FIRST;
                end
            end
            if (err && !(&o_Err_Count))
                o_Err_Count <= o_Err_Count + ERR_CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_seven_seg_dual_reader.sv
// tb_seven_seg_dual_reader: directed checks of filtering, decode, sequencing and error counting
module tb_seven_seg_dual_reader;
    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic [6:0] seg1 = 7'h7F;
    logic [6:0] seg2 = 7'h7F;
    logic [3:0] a_tens, a_units, b_tens, b_units;
    logic [6:0] a_value, b_value;
    logic       a_valid, a_update, a_invalid, a_seq_err;
    logic       b_valid, b_update, b_invalid, b_seq_err;
    logic [7:0] a_err;
    logic [1:0] b_err;
    int errors = 0;
    int checks = 0;

    seven_seg_dual_reader dut_a (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Seg1(seg1), .i_Seg2(seg2),
        .o_Tens(a_tens), .o_Units(a_units), .o_Value(a_value), .o_Valid(a_valid),
        .o_Update(a_update), .o_Invalid(a_invalid), .o_Seq_Err(a_seq_err), .o_Err_Count(a_err)
    );

    seven_seg_dual_reader #(.ERR_CNT_WIDTH(2)) dut_b (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Seg1(seg1), .i_Seg2(seg2),
        .o_Tens(b_tens), .o_Units(b_units), .o_Value(b_value), .o_Valid(b_valid),
        .o_Update(b_update), .o_Invalid(b_invalid), .o_Seq_Err(b_seq_err), .o_Err_Count(b_err)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [6:0] enc(input int d);
        logic [6:0] c;
        case (d)
            0: c = 7'b0111111;
            1: c = 7'b0000110;
            2: c = 7'b1011011;
            3: c = 7'b1001111;
            4: c = 7'b1100110;
            5: c = 7'b1101101;
            6: c = 7'b1111101;
            7: c = 7'b0000111;
            8: c = 7'b1111111;
            default: c = 7'b1101111;
        endcase
        return ~c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [6:0] s1, input logic [6:0] s2, input int n);
        seg1 = s1;
        seg2 = s2;
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic run_val(input int v, input int n);
        run(enc(v / 10), enc(v % 10), n);
    endtask

    // {update, invalid, seq_err, valid, value} of dut_a for compact event checks
    function automatic logic [31:0] ev_a();
        return {21'd0, a_update, a_invalid, a_seq_err, a_valid, a_value};
    endfunction

    function automatic logic [31:0] ev(input bit u, input bit i, input bit s, input bit v, input int val);
        return {21'd0, u, i, s, v, 7'(val)};
    endfunction

    initial begin
        repeat (3) @(posedge i_Clk);
        #1;
        chk("reset_a", {a_tens, a_units, a_value, a_valid, a_update, a_invalid, a_seq_err, a_err}, 0);
        chk("reset_b", {b_value, b_valid, b_update, b_invalid, b_seq_err, b_err}, 0);
        #3 i_Rst_L = 1'b1;
        @(posedge i_Clk);
        #1;
        run_val(0, 4);
        chk("first_00_latency", ev_a(), ev(0, 0, 0, 0, 0));
        run_val(0, 1);
        chk("first_00_accept", ev_a(), ev(1, 0, 0, 1, 0));
        chk("first_00_b_update", b_update, 1);
        run_val(0, 3);
        chk("hold_00_no_repeat", ev_a(), ev(0, 0, 0, 1, 0));
        run_val(1, 5);
        chk("step_01", ev_a(), ev(1, 0, 0, 1, 1));
        run_val(7, 3);
        chk("glitch_07_ignored", ev_a(), ev(0, 0, 0, 1, 1));
        run_val(2, 5);
        chk("step_02", ev_a(), ev(1, 0, 0, 1, 2));
        chk("err_after_02", a_err, 0);
        run_val(98, 5);
        chk("jump_98_seq_err", ev_a(), ev(1, 0, 1, 1, 98));
        chk("digits_98", {a_tens, a_units}, 8'h98);
        chk("err_after_98", a_err, 1);
        run_val(99, 5);
        chk("step_99", ev_a(), ev(1, 0, 0, 1, 99));
        run_val(0, 5);
        chk("wrap_00", ev_a(), ev(1, 0, 0, 1, 0));
        chk("err_after_wrap", a_err, 1);
        run_val(5, 5);
        chk("jump_05_seq_err", ev_a(), ev(1, 0, 1, 1, 5));
        chk("err_after_05", a_err, 2);
        run_val(42, 5);
        chk("jump_42_seq_err", ev_a(), ev(1, 0, 1, 1, 42));
        chk("err_b_at_3", b_err, 3);
        run(enc(4), 7'h7F, 5);
        chk("blank_units_invalid", ev_a(), ev(0, 1, 0, 0, 42));
        chk("digits_hold_42", {a_tens, a_units}, 8'h42);
        chk("err_a_after_blank", a_err, 4);
        chk("err_b_saturated", b_err, 3);
        run_val(17, 5);
        chk("reload_17", ev_a(), ev(1, 0, 0, 1, 17));
        chk("err_after_17", a_err, 4);
        for (int i = 0; i < 5; i++) begin
            run(7'h7F, 7'h7F, 5);
            chk("alt_blank_invalid", {a_invalid, a_valid, b_invalid}, 3'b101);
            run_val(33 + i, 5);
            chk("alt_legal_update", ev_a(), ev(1, 0, 0, 1, 33 + i));
        end
        chk("err_a_after_alt", a_err, 9);
        chk("err_b_after_alt", b_err, 3);
        #3 i_Rst_L = 1'b0;
        #1;
        chk("async_reset_a", {a_tens, a_units, a_value, a_valid, a_update, a_invalid, a_seq_err, a_err}, 0);
        chk("async_reset_b", {b_value, b_valid, b_err}, 0);
        #9 i_Rst_L = 1'b1;
        run_val(37, 4);
        chk("reaccept_latency", ev_a(), ev(0, 0, 0, 0, 0));
        run_val(37, 1);
        chk("reaccept_37", ev_a(), ev(1, 0, 0, 1, 37));
        chk("reaccept_err_zero", {a_err, 6'd0, b_err}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
